// File: rtl/aibndpnr_jtag_pkg.sv
// Shared TAP state encoding, instruction opcodes and IR capture pattern
// for the AIB boundary-scan controller.
package aibndpnr_jtag_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PA_DR  = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PA_IR  = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } tap_state_t;

  localparam logic [4:0] OP_EXTEST      = 5'h00;
  localparam logic [4:0] OP_SAMPLE      = 5'h01;
  localparam logic [4:0] OP_INTEST      = 5'h02;
  localparam logic [4:0] OP_IDCODE      = 5'h03;
  localparam logic [4:0] OP_RST_ASSERT  = 5'h10;
  localparam logic [4:0] OP_RST_RELEASE = 5'h11;
  localparam logic [4:0] OP_BYPASS      = 5'h1F;

  // Fixed pattern loaded in CAP_IR; the trailing 1 lets a host locate the IR.
  localparam logic [4:0] IR_CAPTURE = 5'b00001;

endpackage

// File: rtl/aibndpnr_jtag_ckgate.sv
// Glitch-free clock gate for the BSR clock: enable captured by a latch that is
// transparent while clk is low. Stand-in for the library ICG cell at this boundary.
module aibndpnr_jtag_ckgate (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic gclk
);

  logic en_lat;

  // Clearing the latch on reset kills an in-flight pulse immediately.
  always_latch begin
    if (!rst_n) begin
      en_lat <= 1'b0;
    end else if (!clk) begin
      en_lat <= en;
    end
  end

  assign gclk = clk & en_lat;

endmodule

// File: rtl/aibndpnr_jtag_bscan_ctrl.sv
// 1149.1 TAP controller and instruction decode for the AIB boundary-scan chain:
// drives gated clkdr, shift enable, EXTEST/INTEST selects and the TAP reset override.
module aibndpnr_jtag_bscan_ctrl
  import aibndpnr_jtag_pkg::*;
#(
  parameter int          IR_W   = 5,
  parameter logic [31:0] IDCODE = 32'h0000_0001
) (
  input  logic jtag_tck,
  input  logic jtag_trstb,
  input  logic jtag_tms,
  input  logic jtag_tdi,
  output logic jtag_tdo,
  output logic jtag_tdo_en,
  input  logic jtag_rx_scan_in,
  output logic jtag_tx_scan_out,
  output logic jtag_tx_scanen_out,
  output logic jtag_clkdr_out,
  output logic jtag_mode_out,
  output logic jtag_intest_out,
  output logic jtag_rstb_en_out,
  output logic jtag_rstb_out
);

  tap_state_t      state, state_nxt;
  logic [IR_W-1:0] ir, ir_sh;
  logic [31:0]     id_sh;
  logic            byp;
  logic            mode, intest, rstb_en, rstb;
  logic            tdo_q, tdo_en_q;
  logic            sel_bsr, sel_id, sh_dr, sh_ir, clkdr_en;

  always_ff @(posedge jtag_tck or negedge jtag_trstb) begin
    if (!jtag_trstb) begin
      state <= TLR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:     state_nxt = jtag_tms ? TLR    : RTI;
      RTI:     state_nxt = jtag_tms ? SEL_DR : RTI;
      SEL_DR:  state_nxt = jtag_tms ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = jtag_tms ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = jtag_tms ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = jtag_tms ? UPD_DR : PA_DR;
      PA_DR:   state_nxt = jtag_tms ? EX2_DR : PA_DR;
      EX2_DR:  state_nxt = jtag_tms ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt = jtag_tms ? SEL_DR : RTI;
      SEL_IR:  state_nxt = jtag_tms ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = jtag_tms ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = jtag_tms ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = jtag_tms ? UPD_IR : PA_IR;
      PA_IR:   state_nxt = jtag_tms ? EX2_IR : PA_IR;
      EX2_IR:  state_nxt = jtag_tms ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt = jtag_tms ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  assign sh_dr   = (state == SH_DR);
  assign sh_ir   = (state == SH_IR);
  assign sel_bsr = (ir == OP_EXTEST) | (ir == OP_SAMPLE) | (ir == OP_INTEST);
  assign sel_id  = (ir == OP_IDCODE);

  always_ff @(posedge jtag_tck or negedge jtag_trstb) begin
    if (!jtag_trstb) begin
      ir    <= OP_IDCODE;
      ir_sh <= '0;
    end else begin
      if (state_nxt == TLR) begin
        ir <= OP_IDCODE;
      end else if (state == UPD_IR) begin
        ir <= ir_sh;
      end
      if (state == CAP_IR) begin
        ir_sh <= IR_CAPTURE;
      end else if (sh_ir) begin
        ir_sh <= {jtag_tdi, ir_sh[IR_W-1:1]};
      end
    end
  end

  // Decode lags the IR by one tck so selects never change mid UPD_IR edge.
  always_ff @(posedge jtag_tck or negedge jtag_trstb) begin
    if (!jtag_trstb) begin
      mode    <= 1'b0;
      intest  <= 1'b0;
      rstb_en <= 1'b0;
      rstb    <= 1'b1;
    end else if (state_nxt == TLR) begin
      mode    <= 1'b0;
      intest  <= 1'b0;
      rstb_en <= 1'b0;
      rstb    <= 1'b1;
    end else begin
      mode    <= (ir == OP_EXTEST);
      intest  <= (ir == OP_INTEST);
      rstb_en <= (ir == OP_RST_ASSERT) | (ir == OP_RST_RELEASE);
      rstb    <= (ir != OP_RST_ASSERT);
    end
  end

  always_ff @(posedge jtag_tck or negedge jtag_trstb) begin
    if (!jtag_trstb) begin
      byp   <= 1'b0;
      id_sh <= '0;
    end else if (state == CAP_DR) begin
      byp <= 1'b0;
      if (sel_id) begin
        id_sh <= IDCODE;
      end
    end else if (sh_dr) begin
      byp <= jtag_tdi;
      if (sel_id) begin
        id_sh <= {jtag_tdi, id_sh[31:1]};
      end
    end
  end

  always_ff @(negedge jtag_tck or negedge jtag_trstb) begin
    if (!jtag_trstb) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= sh_ir ? ir_sh[0] : (sh_dr ? (sel_id ? id_sh[0] : byp) : 1'b0);
      tdo_en_q <= sh_ir | sh_dr;
    end
  end

  assign clkdr_en = sel_bsr & ((state == CAP_DR) | sh_dr);

  aibndpnr_jtag_ckgate u_ckgate (
    .clk   (jtag_tck),
    .rst_n (jtag_trstb),
    .en    (clkdr_en),
    .gclk  (jtag_clkdr_out)
  );

  // The chain tail is already negedge-retimed, so it bypasses the TDO flop.
  assign jtag_tx_scanen_out = sel_bsr & sh_dr;
  assign jtag_tdo           = jtag_tx_scanen_out ? jtag_rx_scan_in : tdo_q;
  assign jtag_tdo_en        = tdo_en_q;
  assign jtag_tx_scan_out   = jtag_tdi;
  assign jtag_mode_out      = mode;
  assign jtag_intest_out    = intest;
  assign jtag_rstb_en_out   = rstb_en;
  assign jtag_rstb_out      = rstb;

endmodule
